inst_fetch_responder: RTL and testbench
=======================================

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, the ID driven on arid.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports inst_cache_valid, inst_cache_uncache, inst_cache_tag[19:0], inst_cache_index[7:0] and inst_cache_offset[3:0]: inputs, the fetch request from the preIF stage.
REQ-005 SHALL have port inst_cache_addr_ok, output, 1: request accepted this cycle.
REQ-006 SHALL have port inst_cache_cancel, input, 1: pipeline reflush; discard any in-flight fetch.
REQ-007 SHALL have outputs inst_cache_data_ok (1), inst_cache_rdata[127:0], inst_cache_rmask[3:0] and inst_cache_err (1): the fetch response.
REQ-008 SHALL have AXI read-address outputs arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0] and arvalid, plus input arready.
REQ-009 SHALL have AXI read-data inputs rid[3:0], rdata[31:0], rresp[1:0], rlast and rvalid, plus output rready.

Function
REQ-010 SHALL implement the states IDLE, AR, R and RESP, with exactly one fetch outstanding.
REQ-011 SHALL assert inst_cache_addr_ok combinationally only in IDLE, independent of valid.
- Accept = valid & addr_ok.
- On accept, latch tag, index, offset and uncache, then go to AR next cycle.
REQ-012 SHALL, in AR, hold arvalid=1 and keep every AR field stable until arready; on arvalid & arready, go to R.
REQ-013 SHALL drive cached AR requests (uncache=0) as a line burst.
- araddr={tag,index,4'b0}, arlen=3, arsize=2, arburst=2'b01.
REQ-014 SHALL drive uncached AR requests (uncache=1) as a single beat.
- araddr={tag,index,offset[3:2],2'b00}, arlen=0, arsize=2, arburst=2'b01.
REQ-015 SHALL hold rready=1 in R only; a beat is rvalid & rready.
REQ-016 SHALL write each beat to the 128-bit line buffer, word k at bits [32k+31:32k].
- Cached: k = 2-bit beat counter, starting at 0 and incrementing per beat.
- Uncached: k = offset[3:2].
- rid is ignored.
REQ-017 SHALL set a sticky error flag on any beat with rresp != 2'b00; the flag clears on the next accept.
REQ-018 SHALL, on a beat with rlast=1, go to RESP if the fetch is not cancelled, else to IDLE.
REQ-019 SHALL, in RESP, assert inst_cache_data_ok=1 for exactly one cycle, then go to IDLE; the receiver is always ready.
REQ-020 SHALL drive inst_cache_rmask as follows:
- Cached: bit i = 1 for i >= offset[3:2].
- Uncached: one-hot at offset[3:2].
REQ-021 SHALL hold inst_cache_rdata, inst_cache_rmask and inst_cache_err stable from RESP until the next accept.
REQ-022 SHALL handle inst_cache_cancel per state:
- In AR or R: set a sticky cancelled flag. The AXI transaction still completes in full (AR handshake plus all beats); the fetch then returns to IDLE with no data_ok.
- In RESP: suppress data_ok that cycle and go to IDLE.
- In IDLE: no effect.
- In the same cycle as an accept: the new request is accepted and is NOT cancelled.
- The cancelled flag clears on accept.
REQ-023 SHALL keep latency, with 0-wait AXI, at: accept at t, arvalid at t+1, first beat at t+2, RESP at t+2+arlen+1.

Reset
REQ-024 SHALL, when reset=1 on any edge, force state=IDLE, clear the cancelled and error flags, beat counter=0, line buffer=0 and latched request=0.
- This holds mid-transaction; the outstanding AXI transaction is abandoned.
REQ-025 SHALL, while reset=1, force addr_ok=0, arvalid=0, rready=0 and data_ok=0.
- Reset values of the other outputs: rmask=0, err=0, rdata=0, arid=AXI_ID, araddr=0, arlen=0, arsize=2, arburst=2'b01.

Verification
REQ-026 SHALL cover a cached hit-path fetch.
- Stimulus: tag=0x1FC00, index=0x00, offset=0x4, uncache=0; 0-wait AXI.
- Response: araddr=0x1FC00000, arlen=3; data_ok at accept+6; rmask=4'b1110; rdata words = beats 0..3.
REQ-027 SHALL cover an uncached fetch.
- Stimulus: offset=0xC, uncache=1; arready delayed 3 cycles.
- Response: araddr low nibble=0xC, arlen=0, arvalid held for 4 cycles, rmask=4'b1000, data in rdata[127:96].
REQ-028 SHALL cover cancel during R.
- Stimulus: cancel pulsed after beat 1.
- Response: all 4 beats are still accepted with rready=1; no data_ok; addr_ok returns the cycle after rlast.
REQ-029 SHALL cover cancel in the same cycle as an accept.
- Response: the fetch completes and data_ok is asserted.
REQ-030 SHALL cover an error beat.
- Stimulus: rresp=2'b10 on beat 2.
- Response: err=1 at data_ok; err=0 after the next accept.
REQ-031 SHALL cover reset asserted mid-burst.
- Response: next cycle state=IDLE, addr_ok=1 once reset is released, no data_ok.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: turns one preIF fetch request at a time into
// an AXI read (4-beat line burst when cached, single beat when uncached),
// gathers the beats into a 128-bit line buffer and returns it with a word
// mask and a sticky error flag. A pipeline cancel never aborts the AXI
// transaction; it only suppresses the final data_ok.
module inst_fetch_responder #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         inst_cache_valid,
    input  logic         inst_cache_uncache,
    input  logic [19:0]  inst_cache_tag,
    input  logic [7:0]   inst_cache_index,
    input  logic [3:0]   inst_cache_offset,
    output logic         inst_cache_addr_ok,
    input  logic         inst_cache_cancel,

    output logic         inst_cache_data_ok,
    output logic [127:0] inst_cache_rdata,
    output logic [3:0]   inst_cache_rmask,
    output logic         inst_cache_err,

    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,

    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_next;

    // Latched request; only the word part of the offset matters downstream.
    logic [19:0]  req_tag;
    logic [7:0]   req_index;
    logic [1:0]   req_word;
    logic         req_uncache;

    logic         cancelled;
    logic         err_flag;
    logic [1:0]   beat_cnt;
    logic [127:0] line_buf;
    logic [3:0]   rmask_q;
    logic [7:0]   arlen_q;

    logic         accept;
    logic         ar_fire;
    logic         beat;
    logic [1:0]   beat_word;
    logic         cancel_now;

    // rid and the byte offset within a word carry no information here.
    logic         unused_inputs;
    assign unused_inputs = ^{rid, inst_cache_offset[1:0]};

    assign inst_cache_addr_ok = (state == IDLE) & ~reset;
    assign arvalid            = (state == AR)   & ~reset;
    assign rready             = (state == R)    & ~reset;
    assign inst_cache_data_ok = (state == RESP) & ~inst_cache_cancel & ~reset;

    assign accept  = inst_cache_valid & inst_cache_addr_ok;
    assign ar_fire = arvalid & arready;
    assign beat    = rvalid & rready;

    // A cancel landing on the rlast beat counts just like an earlier one.
    assign cancel_now = cancelled | inst_cache_cancel;

    // Cached bursts fill words in arrival order; uncached fills the addressed word.
    assign beat_word = req_uncache ? req_word : beat_cnt;

    assign arid    = AXI_ID;
    assign araddr  = req_uncache ? {req_tag, req_index, req_word, 2'b00}
                                 : {req_tag, req_index, 4'b0000};
    assign arlen   = arlen_q;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;

    assign inst_cache_rdata = line_buf;
    assign inst_cache_rmask = rmask_q;
    assign inst_cache_err   = err_flag;

    // Next-state selection for the single-outstanding fetch sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = AR;
            AR:   if (ar_fire) state_next = R;
            R:    if (beat && rlast) state_next = cancel_now ? IDLE : RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch plus the mask/length derived from it at accept time.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_tag     <= '0;
            req_index   <= '0;
            req_word    <= '0;
            req_uncache <= 1'b0;
            rmask_q     <= '0;
            arlen_q     <= '0;
        end else if (accept) begin
            req_tag     <= inst_cache_tag;
            req_index   <= inst_cache_index;
            req_word    <= inst_cache_offset[3:2];
            req_uncache <= inst_cache_uncache;
            rmask_q     <= inst_cache_uncache ? (4'b0001 << inst_cache_offset[3:2])
                                              : (4'b1111 << inst_cache_offset[3:2]);
            arlen_q     <= inst_cache_uncache ? 8'd0 : 8'd3;
        end
    end

    // Sticky cancel: set while the AXI transaction is in flight, cleared by a new accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancelled <= 1'b0;
        end else if (accept) begin
            cancelled <= 1'b0;
        end else if (inst_cache_cancel && (state == AR || state == R)) begin
            cancelled <= 1'b1;
        end
    end

    // Sticky error: any non-OKAY beat marks the fetch, cleared by a new accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (accept) begin
            err_flag <= 1'b0;
        end else if (beat && rresp != 2'b00) begin
            err_flag <= 1'b1;
        end
    end

    // Beat counter and line buffer fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            line_buf <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 2'd1;
            line_buf[{beat_word, 5'b00000} +: 32] <= rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a transaction-level model plus a
// per-cycle compare process, and literal expectations for each scenario.
module tb_inst_fetch_responder;

    logic         clk;
    logic         reset;
    logic         valid, uncache, cancel;
    logic [19:0]  tag;
    logic [7:0]   index;
    logic [3:0]   offset;
    logic         addr_ok, data_ok, err;
    logic [127:0] line;
    logic [3:0]   rmask;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    inst_fetch_responder #(.AXI_ID(4'd5)) dut (
        .clk(clk), .reset(reset),
        .inst_cache_valid(valid), .inst_cache_uncache(uncache),
        .inst_cache_tag(tag), .inst_cache_index(index), .inst_cache_offset(offset),
        .inst_cache_addr_ok(addr_ok), .inst_cache_cancel(cancel),
        .inst_cache_data_ok(data_ok), .inst_cache_rdata(line),
        .inst_cache_rmask(rmask), .inst_cache_err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model state: the request of the current fetch and the line it built.
    logic [19:0] m_tag;
    logic [7:0]  m_idx;
    logic [3:0]  m_off;
    logic        m_unc;
    logic [31:0] m_words [4];
    logic        m_err;
    logic [3:0]  m_rmask;
    logic        m_dok;

    // Captures from the most recent fetch, pinned by literal checks.
    logic [31:0]  cap_araddr;
    logic [7:0]   cap_arlen;
    logic [127:0] cap_rdata;
    logic [3:0]   cap_rmask;
    logic         cap_err;
    logic         cap_err_acc;
    logic         cap_dok;
    int           cap_lat;
    int           cap_arv;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] model_rmask(input logic [3:0] off, input logic unc);
        logic [3:0] mk;
        int w;
        w = int'(off[3:2]);
        for (int i = 0; i < 4; i++) mk[i] = unc ? (i == w) : (i >= w);
        return mk;
    endfunction

    function automatic logic [31:0] model_araddr();
        if (m_unc) return {m_tag, m_idx, m_off[3:2], 2'b00};
        return {m_tag, m_idx, 4'b0000};
    endfunction

    function automatic logic [127:0] model_line();
        return {m_words[3], m_words[2], m_words[1], m_words[0]};
    endfunction

    task automatic model_reset();
        m_tag = '0; m_idx = '0; m_off = '0; m_unc = 1'b0;
        for (int i = 0; i < 4; i++) m_words[i] = '0;
        m_err = 1'b0; m_rmask = '0; m_dok = 1'b0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && chk_en) begin
            check("data_ok", {127'd0, data_ok}, {127'd0, m_dok});
            if (arvalid) begin
                check("araddr", {96'd0, araddr}, {96'd0, model_araddr()});
                check("arlen", {120'd0, arlen}, m_unc ? 128'd0 : 128'd3);
                check("arsize", {125'd0, arsize}, 128'd2);
                check("arburst", {126'd0, arburst}, 128'd1);
                check("arid", {124'd0, arid}, 128'd5);
            end
            if (data_ok || addr_ok) begin
                check("rdata", line, model_line());
                check("rmask", {124'd0, rmask}, {124'd0, m_rmask});
                check("err", {127'd0, err}, {127'd0, m_err});
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_addr_ok", {127'd0, addr_ok}, 128'd0);
        check("rst_arvalid", {127'd0, arvalid}, 128'd0);
        check("rst_rready", {127'd0, rready}, 128'd0);
        check("rst_data_ok", {127'd0, data_ok}, 128'd0);
        check("rst_rmask", {124'd0, rmask}, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);
        check("rst_rdata", line, 128'd0);
        check("rst_arid", {124'd0, arid}, 128'd5);
        check("rst_araddr", {96'd0, araddr}, 128'd0);
        check("rst_arlen", {120'd0, arlen}, 128'd0);
        check("rst_arsize", {125'd0, arsize}, 128'd2);
        check("rst_arburst", {126'd0, arburst}, 128'd1);
    endtask

    // One fetch with a scripted AXI slave. cancel_beat/abort_beat = -1 disables.
    task automatic run_fetch(input logic [19:0] t_tag, input logic [7:0] t_idx,
                             input logic [3:0] t_off, input logic t_unc,
                             input int ar_delay, input logic [127:0] words,
                             input logic [7:0] resps, input int cancel_beat,
                             input bit cancel_acc, input bit cancel_resp,
                             input int abort_beat);
        int  t_acc;
        int  n;
        int  k;
        bit  canc;
        cap_dok = 1'b0; cap_lat = -1; cap_arv = 0; cap_err_acc = 1'bx;
        @(posedge clk); #1;
        valid = 1'b1; tag = t_tag; index = t_idx; offset = t_off; uncache = t_unc;
        cancel = cancel_acc;
        @(negedge clk);
        check("accept_addr_ok", {127'd0, addr_ok}, 128'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        valid = 1'b0; cancel = 1'b0;
        m_tag = t_tag; m_idx = t_idx; m_off = t_off; m_unc = t_unc;
        m_err = 1'b0; m_rmask = model_rmask(t_off, t_unc);
        canc = 1'b0;

        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            @(negedge clk);
            check("arvalid_hold", {127'd0, arvalid}, 128'd1);
            if (arvalid) cap_arv++;
            if (c == 0) begin
                cap_araddr  = araddr;
                cap_arlen   = arlen;
                cap_err_acc = err;
                check("err_clr_on_accept", {127'd0, err}, 128'd0);
            end else begin
                check("araddr_stable", {96'd0, araddr}, {96'd0, cap_araddr});
            end
            @(posedge clk); #1;
            arready = 1'b0;
        end

        n = t_unc ? 1 : 4;
        for (int b = 0; b < n; b++) begin
            rvalid = 1'b1;
            rdata  = words[32*b +: 32];
            rresp  = resps[2*b +: 2];
            rlast  = (b == n - 1);
            rid    = 4'($urandom);
            cancel = (b == cancel_beat);
            if (b == abort_beat) reset = 1'b1;
            @(negedge clk);
            if (b == abort_beat) begin
                check("rready_in_reset", {127'd0, rready}, 128'd0);
                @(posedge clk); #1;
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; cancel = 1'b0;
                model_reset();
                @(negedge clk);
                check_reset_vals();
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("addr_ok_after_reset", {127'd0, addr_ok}, 128'd1);
                check("no_data_ok_after_reset", {127'd0, data_ok}, 128'd0);
                return;
            end
            check("rready_beat", {127'd0, rready}, 128'd1);
            k = t_unc ? int'(t_off[3:2]) : b;
            m_words[k] = words[32*b +: 32];
            if (resps[2*b +: 2] != 2'b00) m_err = 1'b1;
            if (b == cancel_beat) canc = 1'b1;
            @(posedge clk); #1;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; cancel = 1'b0;
        end

        if (canc) begin
            m_dok = 1'b0;
            @(negedge clk);
            check("no_data_ok_cancel", {127'd0, data_ok}, 128'd0);
            check("addr_ok_after_rlast", {127'd0, addr_ok}, 128'd1);
        end else begin
            m_dok  = !cancel_resp;
            cancel = cancel_resp;
            @(negedge clk);
            check("resp_data_ok", {127'd0, data_ok}, {127'd0, !cancel_resp});
            cap_dok   = data_ok;
            cap_lat   = cyc - t_acc;
            cap_rdata = line;
            cap_rmask = rmask;
            cap_err   = err;
            @(posedge clk); #1;
            cancel = 1'b0; m_dok = 1'b0;
            @(negedge clk);
            check("idle_after_resp", {127'd0, addr_ok}, 128'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; uncache = 1'b0; cancel = 1'b0;
        tag = '0; index = '0; offset = '0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        check("addr_ok_out_of_reset", {127'd0, addr_ok}, 128'd1);

        // Cached line fetch, 0-wait AXI.
        run_fetch(20'h1FC00, 8'h00, 4'h4, 1'b0, 0,
                  128'h44444444_33333333_22222222_11111111, 8'h00, -1, 0, 0, -1);
        check("c_araddr", {96'd0, cap_araddr}, 128'h1FC00000);
        check("c_arlen", {120'd0, cap_arlen}, 128'd3);
        check("c_latency", 128'(cap_lat), 128'd6);
        check("c_rmask", {124'd0, cap_rmask}, 128'b1110);
        check("c_rdata", cap_rdata, 128'h44444444_33333333_22222222_11111111);
        check("c_dok", {127'd0, cap_dok}, 128'd1);

        // Uncached single beat, arready 3 cycles late.
        run_fetch(20'h1FC00, 8'h01, 4'hC, 1'b1, 3,
                  {96'd0, 32'hDEADBEEF}, 8'h00, -1, 0, 0, -1);
        check("u_araddr", {96'd0, cap_araddr}, 128'h1FC0001C);
        check("u_arlen", {120'd0, cap_arlen}, 128'd0);
        check("u_arvalid_cycles", 128'(cap_arv), 128'd4);
        check("u_rmask", {124'd0, cap_rmask}, 128'b1000);
        check("u_word3", {96'd0, cap_rdata[127:96]}, 128'hDEADBEEF);
        check("u_latency", 128'(cap_lat), 128'd6);

        // Cancel pulsed in the cycle after beat 1.
        run_fetch(20'h12345, 8'hAB, 4'h0, 1'b0, 0,
                  128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 8'h00, 2, 0, 0, -1);
        check("cr_no_dok", {127'd0, cap_dok}, 128'd0);
        check("cr_araddr", {96'd0, cap_araddr}, 128'h12345AB0);

        // Cancel coincident with accept is ignored.
        run_fetch(20'h00ABC, 8'h10, 4'h8, 1'b0, 1,
                  128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 8'h00, -1, 1, 0, -1);
        check("ca_dok", {127'd0, cap_dok}, 128'd1);
        check("ca_rmask", {124'd0, cap_rmask}, 128'b1100);

        // SLVERR on beat 2.
        run_fetch(20'h00001, 8'h02, 4'hC, 1'b0, 0,
                  128'h00000004_00000003_00000002_00000001, 8'h20, -1, 0, 0, -1);
        check("e_err", {127'd0, cap_err}, 128'd1);
        check("e_rmask", {124'd0, cap_rmask}, 128'b1000);

        // Cancel in the response cycle; also error clears on this accept.
        run_fetch(20'h00002, 8'h03, 4'h4, 1'b1, 0,
                  {96'd0, 32'h55AA55AA}, 8'h00, -1, 0, 1, -1);
        check("cresp_err_cleared", {127'd0, cap_err_acc}, 128'd0);
        check("cresp_no_dok", {127'd0, cap_dok}, 128'd0);

        // Reset asserted during beat 1 of a burst.
        run_fetch(20'h0BEEF, 8'h44, 4'h0, 1'b0, 0,
                  128'h99999999_88888888_77777777_66666666, 8'h00, -1, 0, 0, 1);

        // Recovery fetch after the abandoned burst starts from a cleared line.
        run_fetch(20'h00003, 8'h05, 4'h0, 1'b1, 0,
                  {96'd0, 32'hCAFEF00D}, 8'h00, -1, 0, 0, -1);
        check("rec_rdata", cap_rdata, 128'h00000000_00000000_00000000_CAFEF00D);
        check("rec_rmask", {124'd0, cap_rmask}, 128'b0001);
        check("rec_dok", {127'd0, cap_dok}, 128'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
